// File: rtl/mul_serial_unfold.sv
// Digit-serial multiplier: a is loaded in parallel, b arrives J bits per beat
// (LSB digit first), and the exact 2*WIDTH-bit product is offered on a valid/ready port.
module mul_serial_unfold #(
    parameter int WIDTH = 5,
    parameter int J     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 start_ready,
    input  logic                 signed_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [J-1:0]         b_digit,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int D     = (WIDTH + J - 1) / J;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     a_q, a_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic              signed_q, signed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     term;

    // Partial product of the current digit; in signed mode the MSB of b carries
    // negative weight, and positions beyond WIDTH are padding.
    always_comb begin
        term = '0;
        for (int j = 0; j < J; j++) begin
            if ((int'(cnt_q) * J + j) < WIDTH && b_digit[j]) begin
                if (signed_q && (int'(cnt_q) * J + j) == WIDTH - 1)
                    term = term - (a_q << (int'(cnt_q) * J + j));
                else
                    term = term + (a_q << (int'(cnt_q) * J + j));
            end
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        acc_d    = acc_q;
        signed_d = signed_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ACCUM;
                    a_d      = signed_in ? {{WIDTH{a_in[WIDTH-1]}}, a_in}
                                         : {{WIDTH{1'b0}}, a_in};
                    signed_d = signed_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_ACCUM: begin
                if (b_valid) begin
                    acc_d = acc_q + term;
                    if (cnt_q == CNT_W'(D - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: synchronous reset inside the clocked block, using non-blocking updates for all state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            acc_q    <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign b_ready     = (state_q == S_ACCUM);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_ACCUM) || (state_q == S_DONE);
    assign prod        = acc_q;

endmodule

// File: tb/tb_mul_serial_unfold.sv
// Bench for mul_serial_unfold: directed corner cases on J=4 plus random operations
// on J=4, J=1 and J=5 instances against an integer-arithmetic reference.
module tb_mul_serial_unfold;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_in;
    logic [4:0]  a_in;
    logic [4:0]  b_digit_w;
    logic        b_valid;
    logic        out_ready;
    int          sel;

    logic        sr[3], br[3], ov[3], bz[3];
    logic [9:0]  pr[3];

    logic        m_start_ready, m_b_ready, m_out_valid, m_busy;
    logic [9:0]  m_prod;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_serial_unfold #(.WIDTH(5), .J(4)) u_j4 (
        .clk(clk), .reset(reset), .start(start && sel == 0), .start_ready(sr[0]),
        .signed_in(signed_in), .a_in(a_in), .b_digit(b_digit_w[3:0]),
        .b_valid(b_valid && sel == 0), .b_ready(br[0]), .prod(pr[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0])
    );

    mul_serial_unfold #(.WIDTH(5), .J(1)) u_j1 (
        .clk(clk), .reset(reset), .start(start && sel == 1), .start_ready(sr[1]),
        .signed_in(signed_in), .a_in(a_in), .b_digit(b_digit_w[0:0]),
        .b_valid(b_valid && sel == 1), .b_ready(br[1]), .prod(pr[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1])
    );

    mul_serial_unfold #(.WIDTH(5), .J(5)) u_j5 (
        .clk(clk), .reset(reset), .start(start && sel == 2), .start_ready(sr[2]),
        .signed_in(signed_in), .a_in(a_in), .b_digit(b_digit_w),
        .b_valid(b_valid && sel == 2), .b_ready(br[2]), .prod(pr[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .busy(bz[2])
    );

    always_comb begin
        m_start_ready = sr[0];
        m_b_ready     = br[0];
        m_out_valid   = ov[0];
        m_busy        = bz[0];
        m_prod        = pr[0];
        if (sel == 1) begin
            m_start_ready = sr[1]; m_b_ready = br[1]; m_out_valid = ov[1];
            m_busy = bz[1]; m_prod = pr[1];
        end else if (sel == 2) begin
            m_start_ready = sr[2]; m_b_ready = br[2]; m_out_valid = ov[2];
            m_busy = bz[2]; m_prod = pr[2];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ref_prod(input logic [4:0] a, input logic [4:0] b,
                                            input logic sg);
        int av, bv;
        av = (sg && a[4]) ? int'(a) - 32 : int'(a);
        bv = (sg && b[4]) ? int'(b) - 32 : int'(b);
        return 10'(av * bv);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on instance s; pad fills b positions above WIDTH-1.
    task automatic run_op(input int s, input logic [4:0] a, input logic [4:0] b,
                          input logic sg, input logic [14:0] pad, input int gap,
                          input int bp, input logic [9:0] exp, input string tag);
        int jj, dd;
        logic [19:0] bext;
        jj   = (s == 0) ? 4 : (s == 1) ? 1 : 5;
        dd   = (5 + jj - 1) / jj;
        bext = {pad, b};
        sel       = s;
        a_in      = a;
        signed_in = sg;
        start     = 1'b1;
        check({tag, ".start_ready"}, 32'(m_start_ready), 32'd1);
        tick();
        start = 1'b0;
        check({tag, ".busy"}, 32'(m_busy), 32'd1);
        for (int k = 0; k < dd; k++) begin
            if (k > 0) begin
                repeat (gap) begin
                    b_valid   = 1'b0;
                    b_digit_w = 5'($urandom);
                    tick();
                end
            end
            check({tag, ".b_ready"}, 32'(m_b_ready), 32'd1);
            check({tag, ".early_valid"}, 32'(m_out_valid), 32'd0);
            b_valid   = 1'b1;
            b_digit_w = 5'(bext >> (k * jj));
            tick();
            b_valid = 1'b0;
        end
        check({tag, ".out_valid"}, 32'(m_out_valid), 32'd1);
        check({tag, ".prod"}, 32'(m_prod), 32'(exp));
        start = 1'b1;
        repeat (bp) begin
            tick();
            check({tag, ".held_valid"}, 32'(m_out_valid), 32'd1);
            check({tag, ".held_prod"}, 32'(m_prod), 32'(exp));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, ".released"}, 32'(m_out_valid), 32'd0);
        check({tag, ".idle_busy"}, 32'(m_busy), 32'd0);
        check({tag, ".idle_ready"}, 32'(m_start_ready), 32'd1);
    endtask

    initial begin
        logic [4:0] ra, rb;
        logic       rs;
        reset = 1'b1; start = 1'b0; signed_in = 1'b0; a_in = '0;
        b_digit_w = '0; b_valid = 1'b0; out_ready = 1'b0; sel = 0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check("rst.start_ready", 32'(m_start_ready), 32'd1);
            check("rst.out_valid", 32'(m_out_valid), 32'd0);
            check("rst.b_ready", 32'(m_b_ready), 32'd0);
            check("rst.busy", 32'(m_busy), 32'd0);
            check("rst.prod", 32'(m_prod), 32'd0);
        end
        sel = 0;

        b_valid = 1'b1; b_digit_w = 5'h1f;
        tick();
        tick();
        b_valid = 1'b0;
        check("idle_ignores_b", 32'(m_busy), 32'd0);

        run_op(0, 5'd5, 5'd3, 1'b0, 15'h0, 0, 0, 10'd15, "unsigned_5x3");
        run_op(0, 5'b11101, 5'b11110, 1'b1, 15'h7fff, 0, 0, 10'd6, "signed_pad");
        run_op(0, 5'b11101, 5'b11110, 1'b0, 15'h7fff, 0, 0, 10'd870, "unsigned_pad");
        run_op(0, 5'd31, 5'd31, 1'b0, 15'h0, 0, 0, 10'd961, "u31x31");
        run_op(0, 5'b10000, 5'b10000, 1'b1, 15'h0, 0, 0, 10'd256, "sm16xm16");
        run_op(0, 5'b10000, 5'd15, 1'b1, 15'h0, 0, 0, 10'h310, "sm16x15");
        run_op(0, 5'd13, 5'd27, 1'b0, 15'h2a5, 3, 4, 10'd351, "gap_bp");

        sel = 0; a_in = 5'd3; signed_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; b_valid = 1'b1; b_digit_w = 5'h5;
        tick();
        b_valid = 1'b0;
        check("mid.busy", 32'(m_busy), 32'd1);
        reset = 1'b1; b_valid = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; b_valid = 1'b0; start = 1'b0;
        check("abort.start_ready", 32'(m_start_ready), 32'd1);
        check("abort.busy", 32'(m_busy), 32'd0);
        check("abort.prod", 32'(m_prod), 32'd0);
        repeat (4) begin
            tick();
            check("abort.no_valid", 32'(m_out_valid), 32'd0);
        end
        run_op(0, 5'd7, 5'd9, 1'b0, 15'h0, 0, 0, 10'd63, "after_abort");

        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 150; n++) begin
                ra = 5'($urandom);
                rb = 5'($urandom);
                rs = 1'($urandom);
                run_op(s, ra, rb, rs, 15'($urandom), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)), ref_prod(ra, rb, rs), "random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
